// File: rtl/mii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : mii_rx_deframer
// Brief    : MII receive deframer. Strips preamble/SFD, packs bytes into
//            32-bit words and buffers them in a word FIFO for a valid/ready
//            consumer. Optional FCS check enabled by macro RX_CRC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mii_rx_deframer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BYTES  = 1522
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  m_rx_d,
  input  logic        m_rx_en,
  input  logic        m_rx_err,
  output logic [31:0] ff_rx_data,
  output logic        ff_rx_vld,
  output logic        ff_rx_sop,
  output logic        ff_rx_eop,
  output logic [1:0]  ff_rx_mod,
  output logic        ff_rx_err,
  input  logic        ff_rx_rdy,
  output logic [15:0] drop_cnt
);

  localparam int            c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw:0] c_one   = (c_aw + 1)'(1);
  localparam logic [15:0]   c_max   = 16'(MAX_BYTES);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_PREAMBLE  = 2'd2,
    ST_DATA      = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
  } word_t;

  state_t      r_state, w_state_nx;
  logic        r_half;
  logic [3:0]  r_lo;
  logic [31:0] r_word;
  logic [1:0]  r_bidx;
  logic        r_pend_vld;
  logic [31:0] r_pend;
  logic        r_sop_done;
  logic        r_err;
  logic [15:0] r_bcnt;
  logic        r_abort;
  logic        r_term;
  logic [15:0] r_drop;

  logic        w_req, w_start, w_drop_frame, w_ovf, w_space, w_push, w_term_push;
  logic        w_crc_bad, w_err_eop, w_over;
  word_t       w_req_word, w_push_word;
  logic [7:0]  w_byte;
  logic [15:0] w_bcnt_inc;
  logic [31:0] w_word_fill;

  assign w_byte      = {m_rx_d, r_lo};
  assign w_bcnt_inc  = r_bcnt + 16'd1;
  assign w_over      = (w_bcnt_inc > c_max);
  assign w_word_fill = r_word | ({24'd0, w_byte} << {(2'd3 - r_bidx), 3'b000});
  assign w_err_eop   = r_err | w_crc_bad;

`ifdef RX_CRC_CHECK_EN
  localparam logic [31:0] c_residue = 32'hC704DD7B;
  logic [31:0] r_crc, w_crc_nx, w_crc_rev;

  // Reflected LFSR, one byte per completed byte, LSB first.
  always_comb begin
    w_crc_nx = r_crc;
    for (int i = 0; i < 8; i++)
      w_crc_nx = (w_crc_nx >> 1) ^ ((w_crc_nx[0] ^ w_byte[i]) ? 32'hEDB88320 : 32'h0);
    for (int i = 0; i < 32; i++)
      w_crc_rev[i] = r_crc[31-i];
  end

  always_ff @(posedge clk) begin
    if (reset || w_start)
      r_crc <= '1;
    else if (r_state == ST_DATA && m_rx_en && r_half)
      r_crc <= w_crc_nx;
  end

  assign w_crc_bad = (w_crc_rev != c_residue) || (r_bcnt < 16'd4);
`else
  assign w_crc_bad = 1'b0;
`endif

  // Next state and word push request
  always_comb begin
    w_state_nx   = r_state;
    w_req        = 1'b0;
    w_req_word   = '0;
    w_start      = 1'b0;
    w_drop_frame = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: if (!m_rx_en) w_state_nx = ST_IDLE;
      ST_IDLE: begin
        if (m_rx_en) w_state_nx = (m_rx_d == 4'h5) ? ST_PREAMBLE : ST_WAIT_IDLE;
      end
      ST_PREAMBLE: begin
        if (!m_rx_en) begin
          w_state_nx = ST_IDLE;
        end else if (m_rx_d == 4'hD) begin
          if (r_abort) begin
            w_drop_frame = 1'b1;
            w_state_nx   = ST_WAIT_IDLE;
          end else begin
            w_start    = 1'b1;
            w_state_nx = ST_DATA;
          end
        end else if (m_rx_d != 4'h5) begin
          w_state_nx = ST_WAIT_IDLE;
        end
      end
      ST_DATA: begin
        if (!m_rx_en) begin
          w_state_nx = ST_IDLE;
          if (r_pend_vld) begin
            w_req           = 1'b1;
            w_req_word.data = r_pend;
            w_req_word.sop  = !r_sop_done;
            w_req_word.eop  = 1'b1;
            w_req_word.err  = w_err_eop;
          end else if (r_bidx != 2'd0) begin
            w_req           = 1'b1;
            w_req_word.data = r_word;
            w_req_word.sop  = !r_sop_done;
            w_req_word.eop  = 1'b1;
            w_req_word.mod  = 2'd0 - r_bidx;
            w_req_word.err  = w_err_eop;
          end
        end else if (!r_half) begin
          if (r_pend_vld) begin
            w_req           = 1'b1;
            w_req_word.data = r_pend;
            w_req_word.sop  = !r_sop_done;
          end
        end else if (r_bidx == 2'd3 && w_over) begin
          w_req           = 1'b1;
          w_req_word.data = w_word_fill;
          w_req_word.sop  = !r_sop_done;
          w_req_word.eop  = 1'b1;
          w_req_word.err  = 1'b1;
          w_state_nx      = ST_WAIT_IDLE;
        end
      end
      default: w_state_nx = ST_WAIT_IDLE;
    endcase
    if (w_req && !w_space) begin
      w_ovf      = 1'b1;
      w_state_nx = m_rx_en ? ST_WAIT_IDLE : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_WAIT_IDLE;
    else       r_state <= w_state_nx;
  end

  // Byte/word assembly and frame bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_half     <= 1'b0;
      r_lo       <= '0;
      r_word     <= '0;
      r_bidx     <= '0;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_sop_done <= 1'b0;
      r_err      <= 1'b0;
      r_bcnt     <= '0;
      r_abort    <= 1'b0;
      r_term     <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_start) begin
        r_half     <= 1'b0;
        r_word     <= '0;
        r_bidx     <= '0;
        r_pend_vld <= 1'b0;
        r_sop_done <= 1'b0;
        r_err      <= 1'b0;
        r_bcnt     <= '0;
      end else if (r_state == ST_DATA && m_rx_en) begin
        if (m_rx_err) r_err <= 1'b1;
        if (!r_half) begin
          r_lo       <= m_rx_d;
          r_half     <= 1'b1;
          r_pend_vld <= 1'b0;
        end else begin
          r_half <= 1'b0;
          r_bcnt <= w_bcnt_inc;
          if (w_over) r_err <= 1'b1;
          if (r_bidx == 2'd3) begin
            r_pend     <= w_word_fill;
            r_pend_vld <= 1'b1;
            r_word     <= '0;
          end else begin
            r_word <= w_word_fill;
          end
          r_bidx <= r_bidx + 2'd1;
        end
      end
      if (w_req && w_space) r_sop_done <= 1'b1;

      // A terminator is owed only if the aborted frame already opened with sop.
      if (w_ovf) begin
        r_abort <= 1'b1;
        r_term  <= r_sop_done;
      end else if (r_abort && w_space) begin
        r_abort <= 1'b0;
        r_term  <= 1'b0;
      end

      if ((w_ovf || w_drop_frame) && r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;
    end
  end

  // Word FIFO; the output register counts toward FIFO_DEPTH
  word_t         r_mem [FIFO_DEPTH];
  word_t         r_out;
  logic          r_vld;
  logic [c_aw:0] r_wr, r_rd, r_cnt;
  logic          w_pop, w_load, w_mem_empty, w_bypass;

  assign w_pop       = r_vld && ff_rx_rdy;
  assign w_space     = (r_cnt != c_depth) || w_pop;
  assign w_mem_empty = (r_wr == r_rd);
  assign w_load      = !r_vld || w_pop;
  assign w_term_push = r_abort && r_term && w_space;
  assign w_push      = (w_req && w_space) || w_term_push;
  assign w_bypass    = w_load && w_mem_empty && w_push;

  always_comb begin
    w_push_word = w_req_word;
    if (!w_req) begin
      w_push_word     = '0;
      w_push_word.eop = 1'b1;
      w_push_word.err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
      r_out <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_one;
        2'b01:   r_cnt <= r_cnt - c_one;
        default: r_cnt <= r_cnt;
      endcase
      if (w_load) begin
        if (!w_mem_empty) begin
          r_out <= r_mem[r_rd[c_aw-1:0]];
          r_rd  <= r_rd + c_one;
          r_vld <= 1'b1;
        end else if (w_push) begin
          r_out <= w_push_word;
          r_vld <= 1'b1;
        end else begin
          r_out <= '0;
          r_vld <= 1'b0;
        end
      end
      if (w_push && !w_bypass) r_wr <= r_wr + c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_bypass) r_mem[r_wr[c_aw-1:0]] <= w_push_word;
  end

  assign ff_rx_data = r_out.data;
  assign ff_rx_vld  = r_vld;
  assign ff_rx_sop  = r_out.sop;
  assign ff_rx_eop  = r_out.eop;
  assign ff_rx_mod  = r_out.mod;
  assign ff_rx_err  = r_out.err;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mii_rx_deframer
// Brief    : Scoreboard bench for mii_rx_deframer; directed frames queue their
//            expected words, a monitor compares every presented word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mii_rx_deframer;

  localparam int FIFO_DEPTH = 16;
  localparam int MAX_BYTES  = 1522;
`ifdef RX_CRC_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  m_rx_d;
  logic        m_rx_en;
  logic        m_rx_err;
  logic [31:0] ff_rx_data;
  logic        ff_rx_vld;
  logic        ff_rx_sop;
  logic        ff_rx_eop;
  logic [1:0]  ff_rx_mod;
  logic        ff_rx_err;
  logic        ff_rx_rdy;
  logic [15:0] drop_cnt;

  exp_t        exp_q[$];
  exp_t        mon_e, mon_g;
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  frm [0:1699];
  logic [31:0] fcs;

  mii_rx_deframer #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .reset(reset),
    .m_rx_d(m_rx_d), .m_rx_en(m_rx_en), .m_rx_err(m_rx_err),
    .ff_rx_data(ff_rx_data), .ff_rx_vld(ff_rx_vld), .ff_rx_sop(ff_rx_sop),
    .ff_rx_eop(ff_rx_eop), .ff_rx_mod(ff_rx_mod), .ff_rx_err(ff_rx_err),
    .ff_rx_rdy(ff_rx_rdy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: held words are compared against the queue head; transfers pop it
  always @(negedge clk) begin
    if (!reset && ff_rx_vld) begin
      mon_g = {ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_mod, ff_rx_err};
      if (exp_q.size() == 0) begin
        if (ff_rx_rdy) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got data=%h sop=%b eop=%b mod=%0d err=%b",
                   ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_mod, ff_rx_err);
        end
      end else begin
        mon_e = exp_q[0];
        checks++;
        if (mon_g !== mon_e) begin
          failures++;
          $display("FAIL word got data=%h sop=%b eop=%b mod=%0d err=%b exp data=%h sop=%b eop=%b mod=%0d err=%b",
                   mon_g.data, mon_g.sop, mon_g.eop, mon_g.mod, mon_g.err,
                   mon_e.data, mon_e.sop, mon_e.eop, mon_e.mod, mon_e.err);
        end
        if (ff_rx_rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic nib(input logic [3:0] d, input logic en, input logic er);
    m_rx_d   = d;
    m_rx_en  = en;
    m_rx_err = er;
    @(posedge clk);
    #1;
  endtask

  task automatic send_head();
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input int n, input int err_idx, input logic tail);
    send_head();
    for (int i = 0; i < n; i++) begin
      nib(frm[i][3:0], 1'b1, i == err_idx);
      nib(frm[i][7:4], 1'b1, i == err_idx);
    end
    if (tail) nib(4'hA, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) frm[i] = base + 8'(i);
  endtask

  // Expected words of an n-byte frame, first byte in [31:24]
  task automatic expect_frame(input int n, input logic err);
    for (int w = 0; w * 4 < n; w++) begin
      exp_t e;
      e.data = '0;
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < n) e.data[31-8*b -: 8] = frm[w*4+b];
      e.sop = (w == 0);
      e.eop = (w * 4 + 4 >= n);
      e.mod = e.eop ? 2'((4 - (n % 4)) % 4) : 2'd0;
      e.err = e.eop ? err : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c = '1;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c >> 1) ^ ((c[0] ^ frm[i][b]) ? 32'hEDB88320 : 32'h0);
    return ~c;
  endfunction

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    m_rx_d    = '0;
    m_rx_en   = 1'b0;
    m_rx_err  = 1'b0;
    ff_rx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_vld",  ff_rx_vld,  0);
    check("rst_data", ff_rx_data, 0);
    check("rst_sop",  ff_rx_sop,  0);
    check("rst_eop",  ff_rx_eop,  0);
    check("rst_mod",  ff_rx_mod,  0);
    check("rst_err",  ff_rx_err,  0);
    check("rst_drop", drop_cnt,   0);

    // 8 bytes: 0x01020304 sop, 0x05060708 eop mod 0
    fill(8, 8'h01);
    expect_frame(8, CRC_EN);
    send_frame(8, -1, 1'b0);
    wait_drain("drain_8b", 50);

    // 6 bytes: last word 0x05060000 mod 2
    fill(6, 8'h01);
    expect_frame(6, CRC_EN);
    send_frame(6, -1, 1'b0);
    wait_drain("drain_6b", 50);

    // 64 bytes with m_rx_err on byte 10
    fill(64, 8'h10);
    expect_frame(64, 1'b1);
    send_frame(64, 9, 1'b0);
    wait_drain("drain_err", 50);

    // Valid FCS frame, then a copy with one corrupted byte
    fill(60, 8'h30);
    fcs = crc32(60);
    for (int k = 0; k < 4; k++) frm[60+k] = fcs[8*k +: 8];
    expect_frame(64, 1'b0);
    send_frame(64, -1, 1'b0);
    wait_drain("drain_fcs_ok", 50);
    frm[20] = frm[20] ^ 8'h01;
    expect_frame(64, CRC_EN);
    send_frame(64, -1, 1'b0);
    wait_drain("drain_fcs_bad", 50);

    // Short frames, dribble nibble, and a frame with no full byte
    fill(3, 8'hA1);
    expect_frame(3, CRC_EN);
    send_frame(3, -1, 1'b0);
    fill(4, 8'hB1);
    expect_frame(4, CRC_EN);
    send_frame(4, -1, 1'b0);
    fill(5, 8'hC1);
    expect_frame(5, CRC_EN);
    send_frame(5, -1, 1'b1);
    send_frame(0, -1, 1'b1);
    wait_drain("drain_short", 50);

    // Overflow with consumer stalled: 16 words kept, then a terminator
    ff_rx_rdy = 1'b0;
    fill(100, 8'h40);
    expect_frame(64, 1'b0);
    void'(exp_q.pop_back());
    begin
      exp_t e;
      e = '0;
      e.data = {frm[60], frm[61], frm[62], frm[63]};
      exp_q.push_back(e);
      e = '0;
      e.eop = 1'b1;
      e.err = 1'b1;
      exp_q.push_back(e);
    end
    send_frame(100, -1, 1'b0);
    check("drop_after_ovf", drop_cnt, 1);
    fill(8, 8'h01);
    send_frame(8, -1, 1'b0);
    check("drop_during_abort", drop_cnt, 2);
    ff_rx_rdy = 1'b1;
    wait_drain("drain_ovf", 100);
    check("drop_final", drop_cnt, 2);

    // Overlength: word 381 carries bytes 1521..1524, eop with err
    fill(1600, 8'h00);
    expect_frame(1524, 1'b1);
    send_frame(1600, -1, 1'b0);
    wait_drain("drain_long", 100);

    // Reset mid-frame with words buffered
    ff_rx_rdy = 1'b0;
    fill(24, 8'h70);
    send_head();
    for (int i = 0; i < 12; i++) begin
      nib(frm[i][3:0], 1'b1, 1'b0);
      nib(frm[i][7:4], 1'b1, 1'b0);
    end
    reset = 1'b1;
    nib(frm[12][3:0], 1'b1, 1'b0);
    reset = 1'b0;
    check("mid_rst_vld",  ff_rx_vld,  0);
    check("mid_rst_data", ff_rx_data, 0);
    check("mid_rst_drop", drop_cnt,   0);
    ff_rx_rdy = 1'b1;
    nib(frm[12][7:4], 1'b1, 1'b0);
    for (int i = 13; i < 24; i++) begin
      nib(frm[i][3:0], 1'b1, 1'b0);
      nib(frm[i][7:4], 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) nib(4'h0, 1'b0, 1'b0);
    fill(8, 8'h91);
    expect_frame(8, CRC_EN);
    send_frame(8, -1, 1'b0);
    wait_drain("drain_after_rst", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
